enigma_seq_ctrl: RTL and testbench

Character sequencer for the rotor/reflector cipher datapath.
- Accepts a byte stream over a valid/ready handshake.
- Configures the datapath once per message with a set pulse, then issues one character at a time.
- Waits for the datapath done, with a timeout, and returns the result over a valid/ready output handshake.
- Tracks the three rotor positions as an odometer.
- Sits between the host/UART front end and the cipher datapath.

---
 rtl/enigma_pkg.sv | 15 +
 rtl/enigma_step_ctr.sv | 31 +++
 rtl/enigma_seq_ctrl.sv | 110 +++++++++++
 tb/tb_enigma_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants, state type and rotor-position helpers for the cipher sequencer
package enigma_pkg;
  localparam int ALPHA = 26;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  typedef logic [4:0] pos_t;
  localparam pos_t POS_MAX = pos_t'(ALPHA - 1);
  typedef enum logic [2:0] {IDLE, SET, READY, ISSUE, WAIT, OUT, ERR} state_t;
  function automatic pos_t pos_inc(pos_t p);
    return p == POS_MAX ? '0 : p + 5'd1;
  endfunction
  function automatic pos_t pos_mod(pos_t p);
    return p > POS_MAX ? p - pos_t'(ALPHA) : p;
  endfunction
endpackage

// File: rtl/enigma_step_ctr.sv
// enigma_step_ctr: three-digit mod-ALPHA rotor odometer with load and step
module enigma_step_ctr
  import enigma_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic step,
  input  pos_t off1,
  input  pos_t off2,
  input  pos_t off3,
  output pos_t pos1,
  output pos_t pos2,
  output pos_t pos3
);
  // Load reduces offsets into range; a step advances pos1 and ripples carries on wrap
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pos1 <= '0;
      pos2 <= '0;
      pos3 <= '0;
    end else if (load) begin
      pos1 <= pos_mod(off1);
      pos2 <= pos_mod(off2);
      pos3 <= pos_mod(off3);
    end else if (step) begin
      pos1 <= pos_inc(pos1);
      if (pos1 == POS_MAX) pos2 <= pos_inc(pos2);
      if (pos1 == POS_MAX && pos2 == POS_MAX) pos3 <= pos_inc(pos3);
    end
endmodule

// File: rtl/enigma_seq_ctrl.sv
// enigma_seq_ctrl: character sequencer between the host byte stream and the rotor cipher datapath
module enigma_seq_ctrl
  import enigma_pkg::*;
#(
  parameter int SET_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_start,
  input  pos_t       cfg_off1,
  input  pos_t       cfg_off2,
  input  pos_t       cfg_off3,
  input  logic       dec,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       dp_set,
  output logic       dp_en,
  output logic       dp_valid,
  output logic [7:0] dp_din,
  output logic       dp_dec,
  input  logic [7:0] dp_dout,
  input  logic       dp_done,
  output pos_t       pos1,
  output pos_t       pos2,
  output pos_t       pos3,
  output logic       busy,
  output logic       err_timeout
);
  localparam int SW = $clog2(SET_CYCLES + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [SW-1:0] set_cnt;
  logic [CW-1:0] wait_cnt;
  logic load, step, accept, is_letter;
  assign load      = cfg_start && (state inside {IDLE, READY, ERR});
  assign in_ready  = state == READY && !cfg_start;
  assign accept    = in_valid && in_ready;
  assign is_letter = in_data >= ASCII_A && in_data <= ASCII_Z;
  assign step      = state == WAIT && dp_done;
  assign dp_en     = !(state inside {IDLE, ERR});
  assign busy      = !(state inside {IDLE, READY});
  enigma_step_ctr u_step (
    .clk(clk), .reset_n(reset_n), .load(load), .step(step),
    .off1(cfg_off1), .off2(cfg_off2), .off3(cfg_off3),
    .pos1(pos1), .pos2(pos2), .pos3(pos3)
  );
  // Sequencer FSM; wait_cnt is 0 in the first WAIT cycle so the error lands TIMEOUT cycles after dp_valid
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      set_cnt     <= '0;
      wait_cnt    <= '0;
      dp_set      <= 1'b0;
      dp_valid    <= 1'b0;
      dp_din      <= '0;
      dp_dec      <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else if (load) begin
      state       <= SET;
      set_cnt     <= '0;
      dp_set      <= 1'b1;
      dp_dec      <= dec;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        SET:
          if (set_cnt == SW'(SET_CYCLES - 1)) begin
            dp_set <= 1'b0;
            state  <= READY;
          end else set_cnt <= set_cnt + 1'b1;
        READY:
          if (accept && is_letter) begin
            dp_din   <= in_data;
            dp_valid <= 1'b1;
            state    <= ISSUE;
          end else if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        ISSUE: begin
          dp_valid <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT:
          if (dp_done) begin
            out_data  <= dp_dout;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (wait_cnt == CW'(TIMEOUT - 2)) begin
            err_timeout <= 1'b1;
            state       <= ERR;
          end else wait_cnt <= wait_cnt + 1'b1;
        OUT:
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= READY;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// tb_enigma_seq_ctrl: vector table plus scoreboard bench for the cipher sequencer
module tb_enigma_seq_ctrl;
  localparam int TIMEOUT = 64;
  logic clk = 0, reset_n = 1;
  logic cfg_start = 0, dec = 0, in_valid = 0, out_ready = 1;
  logic [4:0] cfg_off1 = 0, cfg_off2 = 0, cfg_off3 = 0;
  logic [7:0] in_data = 0, dp_dout = 0, dp_hold = 0;
  logic dp_done = 0;
  logic in_ready, out_valid, dp_set, dp_en, dp_valid, dp_dec, busy, err_timeout;
  logic [7:0] out_data, dp_din;
  logic [4:0] pos1, pos2, pos3;
  int errors = 0, checks = 0, cyc = 0, dpv_cnt = 0, dpv_cyc = -1, dp_lat = 3, dp_timer = 0;
  bit dp_mute = 0;
  typedef struct { logic [7:0] data; logic [4:0] p1, p2, p3; } exp_t;
  typedef struct { logic [4:0] o1, o2, o3; logic [7:0] din, dout; logic [4:0] p1, p2, p3; } vec_t;
  exp_t sb[$];
  vec_t vecs[9];

  enigma_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start),
    .cfg_off1(cfg_off1), .cfg_off2(cfg_off2), .cfg_off3(cfg_off3), .dec(dec),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .dp_set(dp_set), .dp_en(dp_en), .dp_valid(dp_valid), .dp_din(dp_din), .dp_dec(dp_dec),
    .dp_dout(dp_dout), .dp_done(dp_done),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Datapath model: shifts a letter by one (Z->A) and answers dp_lat+1 cycles after dp_valid
  always @(posedge clk) begin
    dp_done <= 1'b0;
    if (dp_valid && !dp_mute) begin
      dp_timer <= dp_lat;
      dp_hold  <= dp_din == 8'h5A ? 8'h41 : dp_din + 8'd1;
    end else if (dp_timer > 0) begin
      dp_timer <= dp_timer - 1;
      if (dp_timer == 1) begin
        dp_done <= 1'b1;
        dp_dout <= dp_hold;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every completed out handshake pops one expected result
  always @(negedge clk) begin
    if (dp_valid) begin
      dpv_cnt++;
      dpv_cyc = cyc;
    end
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("pos", 32'({pos3, pos2, pos1}), 32'({e.p3, e.p2, e.p1}));
      end
    end
  end

  task automatic configure(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic d);
    int n = 0;
    cfg_off1 = a; cfg_off2 = b; cfg_off3 = c; dec = d; cfg_start = 1;
    @(posedge clk); #1; cfg_start = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin checks++; errors++; $display("FAIL configure: in_ready=0 expected 1"); end
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) begin checks++; errors++; $display("FAIL accept: in_ready=0 expected 1"); end
    @(posedge clk); #1; in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results missing expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    logic [7:0] hold;
    vecs[0] = '{5'd0,  5'd0,  5'd0,  8'h41, 8'h42, 5'd1,  5'd0,  5'd0};
    vecs[1] = '{5'd0,  5'd0,  5'd0,  8'h20, 8'h20, 5'd0,  5'd0,  5'd0};
    vecs[2] = '{5'd25, 5'd25, 5'd25, 8'h5A, 8'h41, 5'd0,  5'd0,  5'd0};
    vecs[3] = '{5'd25, 5'd3,  5'd7,  8'h4D, 8'h4E, 5'd0,  5'd4,  5'd7};
    vecs[4] = '{5'd30, 5'd27, 5'd26, 8'h41, 8'h42, 5'd5,  5'd1,  5'd0};
    vecs[5] = '{5'd3,  5'd4,  5'd5,  8'h40, 8'h40, 5'd3,  5'd4,  5'd5};
    vecs[6] = '{5'd3,  5'd4,  5'd5,  8'h5B, 8'h5B, 5'd3,  5'd4,  5'd5};
    vecs[7] = '{5'd12, 5'd25, 5'd0,  8'h5A, 8'h41, 5'd13, 5'd25, 5'd0};
    vecs[8] = '{5'd25, 5'd24, 5'd3,  8'h50, 8'h51, 5'd0,  5'd25, 5'd3};
    #1 reset_n = 0;
    #1;
    check("reset_ctrl", 32'({in_ready, out_valid, dp_set, dp_en, dp_valid, dp_dec, busy, err_timeout}), 0);
    check("reset_data", 32'({out_data, dp_din, pos1, pos2, pos3}), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("idle_after_reset", 32'({in_ready, busy, dp_en}), 0);
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      configure(vecs[i].o1, vecs[i].o2, vecs[i].o3, logic'(i % 2));
      check("dp_dec", 32'(dp_dec), 32'(i % 2));
      dpv_cnt = 0;
      sb.push_back('{vecs[i].dout, vecs[i].p1, vecs[i].p2, vecs[i].p3});
      send_byte(vecs[i].din);
      if (!(vecs[i].din inside {[8'h41:8'h5A]})) begin
        @(negedge clk);
        check("bypass_latency", 32'(out_valid), 1);
      end
      drain();
      check("dp_valid_cycles", dpv_cnt, (vecs[i].din inside {[8'h41:8'h5A]}) ? 1 : 0);
    end
    configure(5'd0, 5'd0, 5'd0, 1'b0);
    dp_mute = 1; dpv_cyc = -1;
    send_byte(8'h41);
    n = 0;
    while (!err_timeout && n < 200) begin @(negedge clk); n++; end
    check("timeout_flag", 32'(err_timeout), 1);
    check("timeout_cycles", cyc - dpv_cyc, TIMEOUT);
    check("err_outputs", 32'({in_ready, dp_en}), 0);
    dp_mute = 0;
    @(posedge clk); #1;
    cfg_start = 1;
    @(posedge clk); #1; cfg_start = 0;
    check("err_cleared", 32'(err_timeout), 0);
    n = 0;
    repeat (6) begin @(negedge clk); if (dp_set) n++; end
    check("restart_set_cycles", n, 2);
    check("restart_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 0;
    sb.push_back('{8'h43, 5'd1, 5'd0, 5'd0});
    send_byte(8'h42);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    hold = out_data;
    check("bp_data", 32'(hold), 32'h43);
    repeat (10) begin
      @(negedge clk);
      check("bp_hold", 32'({out_valid, in_ready, out_data}), 32'({1'b1, 1'b0, hold}));
    end
    @(posedge clk); #1;
    out_ready = 1;
    drain();
    check("bp_ready_after", 32'(in_ready), 1);
    cfg_start = 1; in_valid = 1; in_data = 8'h41;
    @(negedge clk);
    check("cfg_blocks_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1; cfg_start = 0; in_valid = 0;
    @(negedge clk);
    check("cfg_restart", 32'({dp_set, dp_valid}), 32'b10);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    dp_lat = 8;
    send_byte(8'h41);
    repeat (2) @(posedge clk);
    #3 reset_n = 0;
    #1;
    check("midreset_ctrl", 32'({in_ready, out_valid, dp_set, dp_en, dp_valid, dp_dec, busy, err_timeout}), 0);
    check("midreset_data", 32'({out_data, dp_din, pos1, pos2, pos3}), 0);
    @(posedge clk); #1; reset_n = 1;
    seen = 0; n = 0;
    repeat (12) begin
      @(negedge clk);
      if (dp_done) seen = 1;
      if (out_valid || busy || in_ready) n++;
    end
    check("late_done_seen", 32'(seen), 1);
    check("late_done_ignored", n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
